// File: rtl/z80_rot_dec_exec_if.sv
// Memory handshake bundle for the RLD/RRD execution sequencer.
//   mem_req   : request, held until mem_ack
//   mem_we    : 1 = write, 0 = read; valid while mem_req
//   mem_addr  : request address
//   mem_wdata : write data
//   mem_ack   : completes the current request in the same cycle
//   mem_rdata : read data, valid with mem_ack on a read
// master = sequencer side, slave = memory side.
interface z80_rot_dec_exec_if;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/z80_rot_dec_exec.sv
// Multi-cycle execution sequencer for RLD/RRD (ED 6F / ED 67).
// Reads (HL), rotates nibbles between A and the memory byte, writes the
// result back to (HL), then retires A, F and IP for the z80fi record.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   start, left         : launch pulse (IDLE only); 1 = RLD, 0 = RRD
//   hl_in, a_in, f_in   : HL, A, F at launch
//   ip_in               : address of the ED prefix
//   mem                 : memory req/ack handshake (master side)
//   busy, done          : not-IDLE indicator, one-cycle retire pulse
//   a_out, f_out, ip_out: retired A, F, IP (ip_in + 2)
//   mem_rd_data         : byte read, for the bus record
//   mem_wr_data         : byte written, for the bus record
module z80_rot_dec_exec #(
  parameter int unsigned COMPUTE_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       left,
  input  logic [15:0]                hl_in,
  input  logic [7:0]                 a_in,
  input  logic [7:0]                 f_in,
  input  logic [15:0]                ip_in,
  z80_rot_dec_exec_if.master         mem,
  output logic                       busy,
  output logic                       done,
  output logic [7:0]                 a_out,
  output logic [7:0]                 f_out,
  output logic [15:0]                ip_out,
  output logic [7:0]                 mem_rd_data,
  output logic [7:0]                 mem_wr_data
);

  localparam int unsigned CNT_W = (COMPUTE_CYCLES > 1) ? $clog2(COMPUTE_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_COMPUTE,
    S_WRITE,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic             left_q;
  logic [15:0]      hl_q;
  logic [7:0]       a_q;
  logic [2:0]       fkeep_q;   // F bits 5, 3 and C, which pass through unchanged
  logic [15:0]      ip_q;
  logic [7:0]       m_q;
  logic [CNT_W-1:0] cnt_q;

  logic [7:0]       new_a;
  logic [7:0]       new_m;
  logic [7:0]       new_f;

  // Nibble rotate between A[3:0] and the memory byte; A[7:4] is untouched.
  always_comb begin
    if (left_q) begin
      new_a = {a_q[7:4], m_q[7:4]};
      new_m = {m_q[3:0], a_q[3:0]};
    end else begin
      new_a = {a_q[7:4], m_q[3:0]};
      new_m = {a_q[3:0], m_q[7:4]};
    end
  end

  // F = {S, Z, 5, H, 3, V(parity even), N, C}
  always_comb begin
    new_f = {new_a[7], (new_a == 8'h00), fkeep_q[2], 1'b0,
             fkeep_q[1], ~^new_a, 1'b0, fkeep_q[0]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    busy          = 1'b1;
    done          = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nxt = S_READ;
        end
      end
      S_READ: begin
        mem.mem_req  = 1'b1;
        mem.mem_addr = hl_q;
        if (mem.mem_ack) begin
          state_nxt = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        if (cnt_q == '0) begin
          state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        mem.mem_req   = 1'b1;
        mem.mem_we    = 1'b1;
        mem.mem_addr  = hl_q;
        mem.mem_wdata = new_m;
        if (mem.mem_ack) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      left_q      <= 1'b0;
      hl_q        <= '0;
      a_q         <= '0;
      fkeep_q     <= '0;
      ip_q        <= '0;
      m_q         <= '0;
      cnt_q       <= '0;
      a_out       <= '0;
      f_out       <= '0;
      ip_out      <= '0;
      mem_rd_data <= '0;
      mem_wr_data <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        left_q  <= left;
        hl_q    <= hl_in;
        a_q     <= a_in;
        fkeep_q <= {f_in[5], f_in[3], f_in[0]};
        ip_q    <= ip_in;
      end
      // Counter is loaded on the READ->COMPUTE transition so COMPUTE
      // lasts exactly COMPUTE_CYCLES cycles.
      if (state == S_READ && mem.mem_ack) begin
        m_q   <= mem.mem_rdata;
        cnt_q <= CNT_W'(COMPUTE_CYCLES - 1);
      end
      if (state == S_COMPUTE && cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (state == S_WRITE && mem.mem_ack) begin
        a_out       <= new_a;
        f_out       <= new_f;
        ip_out      <= ip_q + 16'd2;
        mem_rd_data <= m_q;
        mem_wr_data <= new_m;
      end
    end
  end

endmodule
